// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART command parser.
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE, SP1, ADDR, SP2, DATA, EOL, DISCARD,
    EXEC, WAIT_RD, RESP_OK, RESP_ER, RESP_RD
  } state_e;

  typedef enum logic [1:0] {
    RC_OK, RC_ER, RC_RD
  } resp_code_e;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] SP = 8'h20;

  localparam logic [7:0] CH_W_LC = 8'h77;
  localparam logic [7:0] CH_R_LC = 8'h72;

  localparam logic [3:0] RESP_LAST_SHORT = 4'd3;
  localparam logic [3:0] RESP_LAST_RD    = 4'd9;

  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) ||
           (b >= 8'h41 && b <= 8'h46) ||
           (b >= 8'h61 && b <= 8'h66);
  endfunction

  function automatic logic [3:0] hex2nib(input logic [7:0] b);
    if (b <= 8'h39)      return 4'(b - 8'h30);
    else if (b <= 8'h46) return 4'(b - 8'h37);
    else                 return 4'(b - 8'h57);
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Letters only: folds 'W'/'R' onto their lowercase codes.
  function automatic logic [7:0] to_lower(input logic [7:0] b);
    return b | 8'h20;
  endfunction

  function automatic logic is_parse(input state_e s);
    return s inside {IDLE, SP1, ADDR, SP2, DATA, EOL, DISCARD};
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// UART byte streams and register bus seen by the command parser.
interface uart_cmd_parser_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [7:0]        rx_data;
  logic              rx_data_valid;
  logic              rx_data_ready;
  logic [7:0]        tx_data;
  logic              tx_data_valid;
  logic              tx_data_ready;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic              reg_wr;
  logic              reg_rd;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_rd_valid;
  logic              err;

  modport master (
    input  rx_data, rx_data_valid, tx_data_ready, reg_rdata, reg_rd_valid,
    output rx_data_ready, tx_data, tx_data_valid, reg_addr, reg_wdata,
           reg_wr, reg_rd, err
  );

  modport slave (
    output rx_data, rx_data_valid, tx_data_ready, reg_rdata, reg_rd_valid,
    input  rx_data_ready, tx_data, tx_data_valid, reg_addr, reg_wdata,
           reg_wr, reg_rd, err
  );
endinterface

// File: rtl/uart_resp_gen.sv
// Streams one ASCII response ("OK", "ER" or 8 hex digits, then CR LF) over valid/ready.
module uart_resp_gen
  import uart_cmd_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  resp_code_e        code,
  input  logic [DATA_W-1:0] rdata,
  output logic [7:0]        tx_data,
  output logic              tx_data_valid,
  input  logic              tx_data_ready,
  output logic              done
);

  logic              vld_q, vld_d;
  logic [3:0]        idx_q, idx_d;
  resp_code_e        code_q, code_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic       tx_fire;
  logic       last;
  logic [4:0] nib_base;
  logic [7:0] byte_sel;

  always_comb begin
    tx_fire  = vld_q && tx_data_ready;
    last     = (idx_q == ((code_q == RC_RD) ? RESP_LAST_RD : RESP_LAST_SHORT));
    done     = tx_fire && last;
    nib_base = 5'(DATA_W - 1) - {idx_q[2:0], 2'b00};

    byte_sel = 8'h00;
    case (code_q)
      RC_OK: begin
        case (idx_q)
          4'd0:    byte_sel = 8'h4F;
          4'd1:    byte_sel = 8'h4B;
          4'd2:    byte_sel = CR;
          default: byte_sel = LF;
        endcase
      end
      RC_RD: begin
        if (idx_q < 4'd8)       byte_sel = nib2hex(data_q[nib_base -: 4]);
        else if (idx_q == 4'd8) byte_sel = CR;
        else                    byte_sel = LF;
      end
      default: begin
        case (idx_q)
          4'd0:    byte_sel = 8'h45;
          4'd1:    byte_sel = 8'h52;
          4'd2:    byte_sel = CR;
          default: byte_sel = LF;
        endcase
      end
    endcase
    tx_data       = vld_q ? byte_sel : 8'h00;
    tx_data_valid = vld_q;

    vld_d  = vld_q;
    idx_d  = idx_q;
    code_d = code_q;
    data_d = data_q;
    if (start) begin
      vld_d  = 1'b1;
      idx_d  = 4'd0;
      code_d = code;
      data_d = rdata;
    end else if (tx_fire) begin
      if (last) begin
        vld_d = 1'b0;
        idx_d = 4'd0;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      idx_q  <= 4'd0;
      code_q <= RC_OK;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      idx_q  <= idx_d;
      code_q <= code_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "W AA DDDDDDDD<CR>" / "R AA<CR>" lines into register bus accesses
// and hands the matching ASCII reply to uart_resp_gen.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int RD_TIMEOUT = 255,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  uart_cmd_parser_if.master  bus
);

  localparam int TOUT_W = $clog2(RD_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              is_wr_q, is_wr_d;
  logic [3:0]        dig_q, dig_d;
  logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
  logic [DATA_W-1:0] data_sh_q, data_sh_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              reg_wr_q, reg_wr_d;
  logic              reg_rd_q, reg_rd_d;
  logic              rx_ready_q, rx_ready_d;
  logic              err_q, err_d;
  logic [TOUT_W-1:0] tout_q, tout_d;

  logic       rx_fire;
  logic [7:0] b;
  logic [3:0] nib;
  logic       hex;
  logic       resp_start;
  resp_code_e resp_code;
  logic       resp_done;

  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    dig_d       = dig_q;
    addr_sh_d   = addr_sh_q;
    data_sh_d   = data_sh_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    err_d       = err_q;
    tout_d      = tout_q;

    rx_fire = bus.rx_data_valid && rx_ready_q;
    b       = bus.rx_data;
    nib     = hex2nib(b);
    hex     = is_hex(b);

    case (state_q)
      IDLE: if (rx_fire) begin
        if (to_lower(b) == CH_W_LC) begin
          state_d = SP1;
          is_wr_d = 1'b1;
        end else if (to_lower(b) == CH_R_LC) begin
          state_d = SP1;
          is_wr_d = 1'b0;
        end else if (!(b == CR || b == LF || b == SP)) begin
          state_d = DISCARD;
        end
      end
      SP1: if (rx_fire) begin
        if (b == SP) begin
          state_d = ADDR;
          dig_d   = 4'd0;
        end else if (b == CR) begin
          state_d = RESP_ER;
        end else begin
          state_d = DISCARD;
        end
      end
      ADDR: if (rx_fire) begin
        if (hex) begin
          addr_sh_d = {addr_sh_q[ADDR_W-5:0], nib};
          if (dig_q == 4'd1) begin
            dig_d   = 4'd0;
            state_d = is_wr_q ? SP2 : EOL;
          end else begin
            dig_d = dig_q + 4'd1;
          end
        end else if (b == CR) begin
          state_d = RESP_ER;
        end else begin
          state_d = DISCARD;
        end
      end
      SP2: if (rx_fire) begin
        if (b == SP) begin
          state_d = DATA;
          dig_d   = 4'd0;
        end else if (b == CR) begin
          state_d = RESP_ER;
        end else begin
          state_d = DISCARD;
        end
      end
      DATA: if (rx_fire) begin
        if (hex) begin
          data_sh_d = {data_sh_q[DATA_W-5:0], nib};
          if (dig_q == 4'd7) begin
            dig_d   = 4'd0;
            state_d = EOL;
          end else begin
            dig_d = dig_q + 4'd1;
          end
        end else if (b == CR) begin
          state_d = RESP_ER;
        end else begin
          state_d = DISCARD;
        end
      end
      // Bus address/data are latched here so they stay valid through EXEC and beyond.
      EOL: if (rx_fire) begin
        if (b == CR) begin
          state_d     = EXEC;
          reg_addr_d  = addr_sh_q;
          reg_wdata_d = data_sh_q;
          reg_wr_d    = is_wr_q;
          reg_rd_d    = !is_wr_q;
        end else begin
          state_d = DISCARD;
        end
      end
      DISCARD: if (rx_fire && b == CR) state_d = RESP_ER;
      EXEC: begin
        tout_d = '0;
        if (is_wr_q)               state_d = RESP_OK;
        else if (bus.reg_rd_valid) state_d = RESP_RD;
        else                       state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (bus.reg_rd_valid)                   state_d = RESP_RD;
        else if (tout_q == TOUT_W'(RD_TIMEOUT)) state_d = RESP_ER;
        else                                    tout_d  = tout_q + 1'b1;
      end
      RESP_OK, RESP_ER, RESP_RD: if (resp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The generator latches reg_rdata on the start pulse, i.e. the capture cycle.
    resp_start = (state_d != state_q) && (state_d inside {RESP_OK, RESP_ER, RESP_RD});
    resp_code  = RC_OK;
    if (state_d == RESP_ER) resp_code = RC_ER;
    if (state_d == RESP_RD) resp_code = RC_RD;
    if (resp_start && state_d == RESP_ER) err_d = 1'b1;

    rx_ready_d = is_parse(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      is_wr_q     <= 1'b0;
      dig_q       <= 4'd0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      rx_ready_q  <= 1'b0;
      err_q       <= 1'b0;
      tout_q      <= '0;
    end else begin
      state_q     <= state_d;
      is_wr_q     <= is_wr_d;
      dig_q       <= dig_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      rx_ready_q  <= rx_ready_d;
      err_q       <= err_d;
      tout_q      <= tout_d;
    end
  end

  assign bus.rx_data_ready = rx_ready_q;
  assign bus.reg_addr      = reg_addr_q;
  assign bus.reg_wdata     = reg_wdata_q;
  assign bus.reg_wr        = reg_wr_q;
  assign bus.reg_rd        = reg_rd_q;
  assign bus.err           = err_q;

  uart_resp_gen #(.DATA_W(DATA_W)) u_resp_gen (
    .clk           (clk),
    .rst           (rst),
    .start         (resp_start),
    .code          (resp_code),
    .rdata         (bus.reg_rdata),
    .tx_data       (bus.tx_data),
    .tx_data_valid (bus.tx_data_valid),
    .tx_data_ready (bus.tx_data_ready),
    .done          (resp_done)
  );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: command lines in, bus strobes and replies checked.
module tb_uart_cmd_parser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cmd_parser_if bus ();

  uart_cmd_parser #(.RD_TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / read responder state (written only by the negedge process).
  logic [7:0]  txq[$];
  int          wr_cnt = 0, rd_cnt = 0, wr_cyc = 0, rd_cyc = 0;
  int          tv_rise_cyc = 0, rdv_cyc = 0;
  logic [7:0]  wr_addr = 8'h0, rd_addr = 8'h0;
  logic [31:0] wr_data = 32'h0;
  int          hold_viol = 0, hold_cnt = 0, rxr_viol = 0;
  logic        prev_hold = 1'b0, prev_tv = 1'b0;
  logic [7:0]  held = 8'h0;
  int          rd_cnt_dn = 0;

  // Written only by the stimulus process.
  int          rd_delay = -1;
  logic [31:0] rd_value = 32'h0;
  int          acc_cyc = 0;

  always @(negedge clk) begin
    bus.reg_rd_valid = 1'b0;
    bus.reg_rdata    = 32'h0;
    if (rd_cnt_dn > 0) begin
      rd_cnt_dn = rd_cnt_dn - 1;
      if (rd_cnt_dn == 0) begin
        bus.reg_rd_valid = 1'b1;
        bus.reg_rdata    = rd_value;
        rdv_cyc          = cyc;
      end
    end else if (bus.reg_rd === 1'b1 && rd_delay > 0) begin
      rd_cnt_dn = rd_delay;
    end
    if (bus.reg_wr === 1'b1) begin
      wr_cnt++; wr_cyc = cyc; wr_addr = bus.reg_addr; wr_data = bus.reg_wdata;
    end
    if (bus.reg_rd === 1'b1) begin
      rd_cnt++; rd_cyc = cyc; rd_addr = bus.reg_addr;
    end
    if (bus.tx_data_valid === 1'b1 && !prev_tv) tv_rise_cyc = cyc;
    if (bus.tx_data_valid === 1'b1 && bus.rx_data_ready === 1'b1) rxr_viol++;
    if (prev_hold && !rst && (bus.tx_data_valid !== 1'b1 || bus.tx_data !== held)) hold_viol++;
    prev_hold = !rst && bus.tx_data_valid === 1'b1 && bus.tx_data_ready !== 1'b1;
    if (prev_hold) hold_cnt++;
    held = bus.tx_data;
    if (bus.tx_data_valid === 1'b1 && bus.tx_data_ready === 1'b1) txq.push_back(bus.tx_data);
    prev_tv = (bus.tx_data_valid === 1'b1);
  end

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    bus.rx_data       = b;
    bus.rx_data_valid = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bus.rx_data_ready === 1'b1) begin
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
    if (!ok) chk_val("rx_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_resp(input int n, input bit toggle);
    bit ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (toggle) bus.tx_data_ready = ~bus.tx_data_ready;
      if (txq.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk_val("resp_timeout", 64'(txq.size()), 64'(n));
  endtask

  task automatic expect_tx(input string tag, input int base, input string s);
    logic [7:0] obs;
    chk_val({tag, "_len"}, 64'(txq.size() - base), 64'(s.len()));
    for (int i = 0; i < s.len(); i++) begin
      obs = (base + i < txq.size()) ? txq[base + i] : 8'h00;
      chk_val(tag, 64'(obs), 64'(s[i]));
    end
  endtask

  int b_wr, b_rd, b_tx, b_hv, b_hc;

  initial begin
    rst = 1'b1;
    bus.rx_data = 8'h00;
    bus.rx_data_valid = 1'b0;
    bus.tx_data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_val("rst_tx_valid", 64'(bus.tx_data_valid), 64'd0);
    chk_val("rst_tx_data",  64'(bus.tx_data),       64'd0);
    chk_val("rst_rx_ready", 64'(bus.rx_data_ready), 64'd0);
    chk_val("rst_reg_wr",   64'(bus.reg_wr),        64'd0);
    chk_val("rst_reg_rd",   64'(bus.reg_rd),        64'd0);
    chk_val("rst_reg_addr", 64'(bus.reg_addr),      64'd0);
    chk_val("rst_reg_wdata",64'(bus.reg_wdata),     64'd0);
    chk_val("rst_err",      64'(bus.err),           64'd0);
    rst = 1'b0;

    // Write command.
    b_wr = wr_cnt; b_rd = rd_cnt; b_tx = txq.size();
    send_str("W 1A DEADBEEF\r");
    wait_resp(b_tx + 4, 1'b0);
    chk_val("wr_count",   64'(wr_cnt - b_wr), 64'd1);
    chk_val("wr_addr",    64'(wr_addr),       64'h1A);
    chk_val("wr_data",    64'(wr_data),       64'hDEADBEEF);
    chk_val("wr_latency", 64'(wr_cyc - acc_cyc), 64'd1);
    chk_val("wr_tx_lat",  64'(tv_rise_cyc - acc_cyc), 64'd2);
    chk_val("wr_no_rd",   64'(rd_cnt - b_rd), 64'd0);
    expect_tx("wr_tx", b_tx, "OK\r\n");
    chk_val("wr_err",     64'(bus.err), 64'd0);

    // Read command, data returned three cycles after the strobe.
    rd_delay = 3; rd_value = 32'h0123ABCD;
    b_wr = wr_cnt; b_rd = rd_cnt; b_tx = txq.size();
    send_str("r 05\r");
    wait_resp(b_tx + 10, 1'b0);
    chk_val("rd_count",   64'(rd_cnt - b_rd), 64'd1);
    chk_val("rd_addr",    64'(rd_addr),       64'h05);
    chk_val("rd_latency", 64'(rd_cyc - acc_cyc), 64'd1);
    chk_val("rd_rdv_gap", 64'(rdv_cyc - rd_cyc), 64'd3);
    chk_val("rd_tx_lat",  64'(tv_rise_cyc - rdv_cyc), 64'd1);
    chk_val("rd_no_wr",   64'(wr_cnt - b_wr), 64'd0);
    expect_tx("rd_tx", b_tx, "0123ABCD\r\n");
    chk_val("rd_err",     64'(bus.err), 64'd0);

    // Read that never completes: timeout error.
    rd_delay = -1;
    b_wr = wr_cnt; b_rd = rd_cnt; b_tx = txq.size();
    send_str("R 05\r");
    wait_resp(b_tx + 4, 1'b0);
    chk_val("to_rd_count", 64'(rd_cnt - b_rd), 64'd1);
    chk_val("to_delay",    64'(tv_rise_cyc - rd_cyc), 64'd257);
    expect_tx("to_tx", b_tx, "ER\r\n");
    chk_val("to_err",      64'(bus.err), 64'd1);
    chk_val("to_no_wr",    64'(wr_cnt - b_wr), 64'd0);

    // Malformed lines.
    b_wr = wr_cnt;
    b_tx = txq.size();
    send_str("W 1G\r");
    wait_resp(b_tx + 4, 1'b0);
    expect_tx("bad_hex_tx", b_tx, "ER\r\n");
    b_tx = txq.size();
    send_str("X\r");
    wait_resp(b_tx + 4, 1'b0);
    expect_tx("bad_cmd_tx", b_tx, "ER\r\n");
    b_tx = txq.size();
    send_str("W 12 34\r");
    wait_resp(b_tx + 4, 1'b0);
    expect_tx("early_cr_tx", b_tx, "ER\r\n");
    chk_val("bad_no_wr", 64'(wr_cnt - b_wr), 64'd0);
    b_tx = txq.size();
    send_str("\n");
    repeat (20) @(posedge clk);
    #1;
    chk_val("lf_no_tx",   64'(txq.size() - b_tx), 64'd0);
    chk_val("lf_rx_ready",64'(bus.rx_data_ready), 64'd1);
    chk_val("lf_err",     64'(bus.err), 64'd1);

    // Transmit backpressure.
    b_tx = txq.size(); b_hv = hold_viol; b_hc = hold_cnt;
    send_str("W 33 00000010\r");
    wait_resp(b_tx + 4, 1'b1);
    bus.tx_data_ready = 1'b1;
    expect_tx("bp_tx", b_tx, "OK\r\n");
    chk_val("bp_hold_seen", 64'(hold_cnt > b_hc), 64'd1);
    chk_val("bp_hold_stable", 64'(hold_viol - b_hv), 64'd0);
    chk_val("bp_rx_ready_off", 64'(rxr_viol), 64'd0);
    chk_val("bp_wr_data", 64'(wr_data), 64'h10);

    // Reset in the middle of a response.
    b_tx = txq.size();
    send_str("W 10 00000005\r");
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (txq.size() >= b_tx + 1) break;
    end
    rst = 1'b1;
    bus.tx_data_ready = 1'b0;
    @(posedge clk); #1;
    chk_val("mr_tx_valid", 64'(bus.tx_data_valid), 64'd0);
    chk_val("mr_reg_wr",   64'(bus.reg_wr),        64'd0);
    chk_val("mr_rx_ready", 64'(bus.rx_data_ready), 64'd0);
    chk_val("mr_err",      64'(bus.err),           64'd0);
    chk_val("mr_reg_addr", 64'(bus.reg_addr),      64'd0);
    chk_val("mr_reg_wdata",64'(bus.reg_wdata),     64'd0);
    chk_val("mr_tx_bytes", 64'(txq.size() - b_tx), 64'd1);
    rst = 1'b0;
    bus.tx_data_ready = 1'b1;
    b_wr = wr_cnt; b_tx = txq.size();
    send_str("W 00 00000001\r");
    wait_resp(b_tx + 4, 1'b0);
    expect_tx("post_rst_tx", b_tx, "OK\r\n");
    chk_val("post_rst_wr",   64'(wr_cnt - b_wr), 64'd1);
    chk_val("post_rst_addr", 64'(wr_addr), 64'h00);
    chk_val("post_rst_data", 64'(wr_data), 64'h1);
    chk_val("post_rst_err",  64'(bus.err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
